// File: rtl/uart_pkt_rx.sv
// 8N1 UART receiver with a sync-header packet framer: forwards PKT_BYTES payload
// bytes as strobes into the byte-to-word FIFO and checks a trailing additive checksum.
//
// Bit FSM:
//   state    | meaning
//   R_IDLE   | line idle, waiting for a low level on rxs
//   R_START  | timing to start-bit centre, rejects glitches
//   R_DATA   | sampling 8 data bits LSB first at bit centres
//   R_STOP   | sampling stop bit, emits byte strobe or framing error
// Packet FSM:
//   state     | meaning
//   P_SYNC0   | hunting for first header byte (pkt_en gates the start)
//   P_SYNC1   | first header byte seen, expecting second
//   P_PAYLOAD | forwarding payload bytes and accumulating the sum
//   P_CSUM    | waiting for the checksum byte

module uart_pkt_rx #(
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          BAUD      = 115200,
  parameter int          PKT_BYTES = 512,
  parameter logic [7:0]  SYNC0     = 8'h55,
  parameter logic [7:0]  SYNC1     = 8'hAA
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       pkt_en,
  output logic [7:0] byte_out,
  output logic       byte_out_valid,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int          BAUD_DIV = CLK_FREQ / BAUD;
  localparam int          HALF_DIV = BAUD_DIV / 2;
  localparam logic [15:0] BAUD_TC  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_TC  = 16'(HALF_DIV - 1);
  localparam logic [15:0] PKT_LAST = 16'(PKT_BYTES - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  typedef enum logic [1:0] {P_SYNC0, P_SYNC1, P_PAYLOAD, P_CSUM} pstate_t;

  logic        sync1_q, rxs_q;
  rstate_t     rstate_q, rstate_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_strobe_q, rx_strobe_d;
  logic        frame_err_q, frame_err_d;

  pstate_t     pstate_q, pstate_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        perr_q, perr_d;
  logic        busy_w;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    rstate_d    = rstate_q;
    baud_cnt_d  = baud_cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        baud_cnt_d = '0;
        if (!rxs_q) rstate_d = R_START;
      end
      R_START: begin
        if (baud_cnt_q == HALF_TC) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          rstate_d   = rxs_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (baud_cnt_q == BAUD_TC) begin
          baud_cnt_d = '0;
          shift_d    = {rxs_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rstate_d = R_STOP;
        end
      end
      R_STOP: begin
        // Return to idle at stop-bit centre so a back-to-back start edge is caught.
        if (baud_cnt_q == BAUD_TC) begin
          baud_cnt_d = '0;
          rstate_d   = R_IDLE;
          if (rxs_q) rx_strobe_d = 1'b1;
          else       frame_err_d = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q    <= R_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rstate_q    <= rstate_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_strobe_q <= rx_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign busy_w = (pstate_q == P_PAYLOAD) || (pstate_q == P_CSUM);

  always_comb begin
    pstate_d   = pstate_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    byte_out_d = byte_out_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    perr_d     = 1'b0;
    // Abort acts on the un-registered framing error so pkt_err lines up with frame_err.
    if (frame_err_d && busy_w) begin
      perr_d   = 1'b1;
      pstate_d = P_SYNC0;
    end else if (rx_strobe_q) begin
      case (pstate_q)
        P_SYNC0: begin
          if (shift_q == SYNC0 && pkt_en) pstate_d = P_SYNC1;
        end
        P_SYNC1: begin
          if (shift_q == SYNC1) begin
            pstate_d   = P_PAYLOAD;
            byte_cnt_d = '0;
            sum_d      = '0;
          end else if (shift_q != SYNC0) begin
            pstate_d = P_SYNC0;
          end
        end
        P_PAYLOAD: begin
          byte_out_d = shift_q;
          valid_d    = 1'b1;
          sum_d      = sum_q + shift_q;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == PKT_LAST) pstate_d = P_CSUM;
        end
        P_CSUM: begin
          if (shift_q == sum_q) done_d = 1'b1;
          else                  perr_d = 1'b1;
          pstate_d = P_SYNC0;
        end
        default: pstate_d = P_SYNC0;
      endcase
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q   <= P_SYNC0;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      byte_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      byte_out_q <= byte_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
    end
  end

  assign byte_out       = byte_out_q;
  assign byte_out_valid = valid_q;
  assign pkt_done       = done_q;
  assign pkt_err        = perr_q;
  assign frame_err      = frame_err_q;
  assign busy           = busy_w;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx at BAUD_DIV=10, PKT_BYTES=8; a negedge monitor
// counts output pulses and records forwarded bytes, scenario tasks compare deltas.

module tb_uart_pkt_rx;

  logic       src_clk = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  logic       pkt_en;
  logic [7:0] byte_out;
  logic       byte_out_valid;
  logic       pkt_done;
  logic       pkt_err;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int n_valid, n_done, n_err, n_ferr, n_fe_pe, n_done_err;
  logic [7:0] seen [0:255];

  uart_pkt_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .PKT_BYTES(8),
    .SYNC0    (8'h55),
    .SYNC1    (8'hAA)
  ) dut (
    .src_clk       (src_clk),
    .rst_n         (rst_n),
    .uart_rxd      (uart_rxd),
    .pkt_en        (pkt_en),
    .byte_out      (byte_out),
    .byte_out_valid(byte_out_valid),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 src_clk = ~src_clk;

  initial begin
    n_valid = 0; n_done = 0; n_err = 0; n_ferr = 0; n_fe_pe = 0; n_done_err = 0;
  end

  always @(negedge src_clk) begin
    if (rst_n) begin
      if (byte_out_valid) begin
        seen[n_valid[7:0]] <= byte_out;
        n_valid <= n_valid + 1;
      end
      if (pkt_done)              n_done     <= n_done + 1;
      if (pkt_err)               n_err      <= n_err + 1;
      if (frame_err)             n_ferr     <= n_ferr + 1;
      if (frame_err && pkt_err)  n_fe_pe    <= n_fe_pe + 1;
      if (pkt_done && pkt_err)   n_done_err <= n_done_err + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rxd = 1'b0;
    repeat (10) @(negedge src_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (10) @(negedge src_clk);
    end
    if (good_stop) begin
      uart_rxd = 1'b1;
      repeat (10) @(negedge src_clk);
    end else begin
      // low across the stop-bit centre, high again before the receiver re-arms
      uart_rxd = 1'b0;
      repeat (6) @(negedge src_clk);
      uart_rxd = 1'b1;
      repeat (4) @(negedge src_clk);
    end
  endtask

  task automatic send_pkt(input logic [7:0] csum);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    send_byte(csum, 1'b1);
    repeat (20) @(negedge src_clk);
  endtask

  task automatic test_reset();
    if (byte_out !== 8'h00)      begin bad++; $display("FAIL rst_byte_out got=%h exp=00", byte_out); end
    total++;
    if (byte_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", byte_out_valid); end
    total++;
    if (pkt_done !== 1'b0)       begin bad++; $display("FAIL rst_done got=%b exp=0", pkt_done); end
    total++;
    if (pkt_err !== 1'b0)        begin bad++; $display("FAIL rst_err got=%b exp=0", pkt_err); end
    total++;
    if (frame_err !== 1'b0)      begin bad++; $display("FAIL rst_ferr got=%b exp=0", frame_err); end
    total++;
    if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++;
  endtask

  task automatic test_good_packet();
    int v0, d0, e0;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    if (busy !== 1'b1) begin bad++; $display("FAIL good_busy_hdr got=%b exp=1", busy); end
    total++;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h24, 1'b1);
    repeat (20) @(negedge src_clk);
    if (n_valid - v0 !== 8) begin bad++; $display("FAIL good_valids got=%0d exp=8", n_valid - v0); end
    total++;
    for (int i = 0; i < 8; i++) begin
      if (seen[8'(v0 + i)] !== 8'(i + 1)) begin
        bad++; $display("FAIL good_byte%0d got=%h exp=%h", i, seen[8'(v0 + i)], 8'(i + 1));
      end
      total++;
    end
    if (n_done - d0 !== 1) begin bad++; $display("FAIL good_done got=%0d exp=1", n_done - d0); end
    total++;
    if (n_err - e0 !== 0)  begin bad++; $display("FAIL good_err got=%0d exp=0", n_err - e0); end
    total++;
    if (busy !== 1'b0)     begin bad++; $display("FAIL good_busy_end got=%b exp=0", busy); end
    total++;
    if (byte_out !== 8'h08) begin bad++; $display("FAIL good_byte_hold got=%h exp=08", byte_out); end
    total++;
  endtask

  task automatic test_bad_csum();
    int v0, d0, e0;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    send_pkt(8'h25);
    if (n_valid - v0 !== 8) begin bad++; $display("FAIL badcs_valids got=%0d exp=8", n_valid - v0); end
    total++;
    if (n_err - e0 !== 1)   begin bad++; $display("FAIL badcs_err got=%0d exp=1", n_err - e0); end
    total++;
    if (n_done - d0 !== 0)  begin bad++; $display("FAIL badcs_done got=%0d exp=0", n_done - d0); end
    total++;
    d0 = n_done;
    send_pkt(8'h24);
    if (n_done - d0 !== 1)  begin bad++; $display("FAIL badcs_recover got=%0d exp=1", n_done - d0); end
    total++;
  endtask

  task automatic test_sync_hunt();
    int v0, d0;
    v0 = n_valid; d0 = n_done;
    send_byte(8'h55, 1'b1);
    send_pkt(8'h24);
    if (n_valid - v0 !== 8) begin bad++; $display("FAIL hunt_dup_valids got=%0d exp=8", n_valid - v0); end
    total++;
    if (n_done - d0 !== 1)  begin bad++; $display("FAIL hunt_dup_done got=%0d exp=1", n_done - d0); end
    total++;
    v0 = n_valid;
    send_byte(8'h55, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (20) @(negedge src_clk);
    if (n_valid - v0 !== 0) begin bad++; $display("FAIL hunt_broken_valids got=%0d exp=0", n_valid - v0); end
    total++;
    if (busy !== 1'b0)      begin bad++; $display("FAIL hunt_broken_busy got=%b exp=0", busy); end
    total++;
  endtask

  task automatic test_glitch();
    int v0, d0, f0;
    v0 = n_valid; d0 = n_done; f0 = n_ferr;
    uart_rxd = 1'b0;
    repeat (3) @(negedge src_clk);
    uart_rxd = 1'b1;
    repeat (120) @(negedge src_clk);
    if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_valids got=%0d exp=0", n_valid - v0); end
    total++;
    if (n_ferr - f0 !== 0)  begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - f0); end
    total++;
    send_pkt(8'h24);
    if (n_done - d0 !== 1)  begin bad++; $display("FAIL glitch_next_done got=%0d exp=1", n_done - d0); end
    total++;
  endtask

  task automatic test_frame_err();
    int v0, d0, e0, f0, c0;
    v0 = n_valid; d0 = n_done; e0 = n_err; f0 = n_ferr; c0 = n_fe_pe;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h04, 1'b0);
    repeat (5) @(negedge src_clk);
    if (busy !== 1'b0)      begin bad++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    total++;
    for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h24, 1'b1);
    repeat (20) @(negedge src_clk);
    if (n_ferr - f0 !== 1)  begin bad++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
    total++;
    if (n_err - e0 !== 1)   begin bad++; $display("FAIL ferr_pkt_err got=%0d exp=1", n_err - e0); end
    total++;
    if (n_fe_pe - c0 !== 1) begin bad++; $display("FAIL ferr_same_cycle got=%0d exp=1", n_fe_pe - c0); end
    total++;
    if (n_valid - v0 !== 3) begin bad++; $display("FAIL ferr_valids got=%0d exp=3", n_valid - v0); end
    total++;
    if (n_done - d0 !== 0)  begin bad++; $display("FAIL ferr_done got=%0d exp=0", n_done - d0); end
    total++;
    v0 = n_valid; d0 = n_done;
    pkt_en = 1'b0;
    send_pkt(8'h24);
    pkt_en = 1'b1;
    if (n_valid - v0 !== 0) begin bad++; $display("FAIL noen_valids got=%0d exp=0", n_valid - v0); end
    total++;
    if (n_done - d0 !== 0)  begin bad++; $display("FAIL noen_done got=%0d exp=0", n_done - d0); end
    total++;
  endtask

  task automatic test_reset_mid();
    int v0, d0, e0;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    if (byte_out !== 8'h05) begin bad++; $display("FAIL midrst_pre_byte got=%h exp=05", byte_out); end
    total++;
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (3) @(negedge src_clk);
    rst_n = 1'b1;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    for (int i = 6; i <= 8; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h24, 1'b1);
    repeat (20) @(negedge src_clk);
    if ((n_valid - v0) + (n_done - d0) + (n_err - e0) !== 0) begin
      bad++; $display("FAIL midrst_quiet got=%0d exp=0", (n_valid - v0) + (n_done - d0) + (n_err - e0));
    end
    total++;
    v0 = n_valid; d0 = n_done;
    send_pkt(8'h24);
    if (n_valid - v0 !== 8) begin bad++; $display("FAIL midrst_valids got=%0d exp=8", n_valid - v0); end
    total++;
    if (n_done - d0 !== 1)  begin bad++; $display("FAIL midrst_done got=%0d exp=1", n_done - d0); end
    total++;
  endtask

  initial begin
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    pkt_en   = 1'b1;
    repeat (3) @(negedge src_clk);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge src_clk);
    test_reset();
    test_good_packet();
    test_bad_csum();
    test_sync_hunt();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    if (n_done_err !== 0) begin bad++; $display("FAIL done_err_overlap got=%0d exp=0", n_done_err); end
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
